// File: rtl/ptmch_trg_multi.sv
// ptmch_trg_multi: multi-channel SPI instruction snooper and trigger generator.
// The first byte of every SPI transaction is taken as the instruction opcode.
// Each channel compares it against its own opcode and, on a match, produces a
// delayed, fixed-width trigger pulse for scope/logic-analyser use.
// Everything runs in the CLK160M domain. The SPI lines are treated as
// asynchronous and are resynchronised before use.

module ptmch_trg_multi #(
    parameter int N_CH = 4,
    parameter logic [8*N_CH-1:0] CH_OPCODE = 32'h1384_1002,
    parameter int DELAY = 0,
    parameter int PULSE_LEN = 15,
    parameter int RETRIG = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic            CLK160M,
    input  logic            RESET,
    input  logic            SPI_CS,
    input  logic            SPI_CLK,
    input  logic            SPI_MOSI,
    output logic [N_CH-1:0] TRG_PLS,
    output logic            OP_VLD,
    output logic [7:0]      OP_DATA,
    output logic [N_CH-1:0] DROP
);

    // Counter reload values. With DELAY=0 the delay phase is skipped entirely,
    // so its reload value is never used.
    localparam logic [7:0] DLY_LOAD  = (DELAY > 0) ? 8'(DELAY - 1) : 8'd0;
    localparam logic [7:0] PLS_LOAD  = 8'(PULSE_LEN - 1);
    localparam logic [3:0] BYTE_BITS = 4'd8;
    localparam logic [3:0] LAST_BIT  = 4'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DLY  = 2'd1,
        PLS  = 2'd2
    } ch_state_t;

    logic [SYNC_STAGES-1:0] cs_pipe;
    logic [SYNC_STAGES-1:0] sclk_pipe;
    logic [SYNC_STAGES-1:0] mosi_pipe;
    logic                   sclk_hist;
    logic                   cs_sync;
    logic                   sclk_sync;
    logic                   mosi_sync;
    logic                   sclk_rise;

    logic [3:0]             bit_cnt;
    logic [7:0]             shift;
    logic                   byte_done;

    assign cs_sync   = cs_pipe[SYNC_STAGES-1];
    assign sclk_sync = sclk_pipe[SYNC_STAGES-1];
    assign mosi_sync = mosi_pipe[SYNC_STAGES-1];
    assign sclk_rise = sclk_sync & ~sclk_hist;

    // Resynchronise the SPI lines. CS and CLK reset to their idle-high level,
    // so neither a false transaction start nor a false clock edge is seen.
    always_ff @(posedge CLK160M) begin
        if (RESET) begin
            cs_pipe   <= '1;
            sclk_pipe <= '1;
            mosi_pipe <= '0;
            sclk_hist <= 1'b1;
        end else begin
            cs_pipe   <= {cs_pipe[SYNC_STAGES-2:0], SPI_CS};
            sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], SPI_CLK};
            mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], SPI_MOSI};
            sclk_hist <= sclk_sync;
        end
    end

    // Shift in the first eight bits of a transaction. The bit counter
    // saturates at eight, so later bytes under the same CS are ignored.
    // byte_done flags the cycle in which the eighth bit has just landed.
    always_ff @(posedge CLK160M) begin
        if (RESET) begin
            bit_cnt   <= 4'd0;
            shift     <= 8'h00;
            byte_done <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            if (cs_sync) begin
                bit_cnt <= 4'd0;
                shift   <= 8'h00;
            end else if (sclk_rise && (bit_cnt < BYTE_BITS)) begin
                shift   <= {shift[6:0], mosi_sync};
                bit_cnt <= bit_cnt + 4'd1;
                if (bit_cnt == LAST_BIT) begin
                    byte_done <= 1'b1;
                end
            end
        end
    end

    // Publish the captured instruction: a one-cycle strobe and a held byte.
    // Reading shift here is safe even if CS has just risen, because the
    // clear of shift takes effect on this same edge.
    always_ff @(posedge CLK160M) begin
        if (RESET) begin
            OP_VLD  <= 1'b0;
            OP_DATA <= 8'h00;
        end else begin
            OP_VLD <= byte_done;
            if (byte_done) begin
                OP_DATA <= shift;
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        localparam logic [7:0] OPCODE = CH_OPCODE[8*i +: 8];

        ch_state_t  state;
        logic [7:0] cnt;
        logic       trg;
        logic       drop;
        logic       hit;
        logic       restart;

        assign hit     = OP_VLD && (OP_DATA == OPCODE);
        assign restart = hit && ((state == IDLE) || (RETRIG != 0));
        assign TRG_PLS[i] = trg;
        assign DROP[i]    = drop;

        // Channel sequencer: optional delay phase, then a pulse of exactly
        // PULSE_LEN cycles. The pulse output is registered and goes high on
        // the same edge that enters the pulse phase.
        always_ff @(posedge CLK160M) begin
            if (RESET) begin
                state <= IDLE;
                cnt   <= 8'd0;
                trg   <= 1'b0;
                drop  <= 1'b0;
            end else if (restart) begin
                if (DELAY > 0) begin
                    state <= DLY;
                    cnt   <= DLY_LOAD;
                    trg   <= 1'b0;
                end else begin
                    state <= PLS;
                    cnt   <= PLS_LOAD;
                    trg   <= 1'b1;
                end
            end else begin
                if (hit) begin
                    drop <= 1'b1;
                end
                case (state)
                    IDLE: begin
                        trg <= 1'b0;
                    end
                    DLY: begin
                        if (cnt == 8'd0) begin
                            state <= PLS;
                            cnt   <= PLS_LOAD;
                            trg   <= 1'b1;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                    PLS: begin
                        if (cnt == 8'd0) begin
                            state <= IDLE;
                            trg   <= 1'b0;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        trg   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ptmch_trg_multi.sv
// tb_ptmch_trg_multi: bench for ptmch_trg_multi.
// Four instances with different timing parameters share one SPI bus. The
// bench records every instruction byte it sends and the cycle at which the
// byte must be complete inside the DUT, and derives all expected outputs from
// that list with interval arithmetic.

module tb_ptmch_trg_multi;

    localparam int S  = 2;
    localparam int ND = 4;
    localparam logic [31:0] OPCODES = 32'h1384_1002;
    // Per-instance parameters, instance g in byte/bit g.
    localparam logic [31:0] DLY_PK = {8'd0, 8'd0, 8'd5, 8'd0};
    localparam logic [31:0] PL_PK  = {8'd60, 8'd60, 8'd3, 8'd15};
    localparam logic [3:0]  RT_PK  = 4'b1000;

    typedef struct {
        int         t;
        logic [7:0] b;
    } cap_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs = 1'b1;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic [3:0] trg [ND];
    logic [3:0] drp [ND];
    logic       vld [ND];
    logic [7:0] dat [ND];

    cap_t cap_q[$];
    int   cyc = 0;
    int   last_rst = 0;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 0;

    int   hi_cnt   [ND][4];
    int   first_hi [ND][4];
    int   rise_cnt [ND][4];
    logic [3:0] prev_trg [ND];
    int   vld_cnt;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        ptmch_trg_multi #(
            .N_CH(4),
            .CH_OPCODE(OPCODES),
            .DELAY(int'(DLY_PK[8*g +: 8])),
            .PULSE_LEN(int'(PL_PK[8*g +: 8])),
            .RETRIG(int'(RT_PK[g])),
            .SYNC_STAGES(S)
        ) dut (
            .CLK160M(clk),
            .RESET(rst),
            .SPI_CS(cs),
            .SPI_CLK(sclk),
            .SPI_MOSI(mosi),
            .TRG_PLS(trg[g]),
            .OP_VLD(vld[g]),
            .OP_DATA(dat[g]),
            .DROP(drp[g])
        );
    end

    always #3 clk = ~clk;

    // Count rising edges and remember the most recent edge that sampled reset.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            last_rst <= cyc + 1;
        end
    end

    function automatic int p_dly(input int g);
        return int'(DLY_PK[8*g +: 8]);
    endfunction

    function automatic int p_pl(input int g);
        return int'(PL_PK[8*g +: 8]);
    endfunction

    // Expected pulse/drop state of one channel after edge c, from the hits.
    // A hit lands two edges after its byte completes. With retrigger the
    // latest hit owns the pulse; without, hits inside a busy window are dropped.
    function automatic void model_ch(input int d, input int pl, input bit rt,
                                     input logic [7:0] op, input int c,
                                     output logic t, output logic dr);
        int  start;
        bit  act;
        start = 0;
        act   = 0;
        t     = 1'b0;
        dr    = 1'b0;
        foreach (cap_q[k]) begin
            int h;
            h = cap_q[k].t + 2;
            if ((cap_q[k].t > last_rst) && (h <= c) && (cap_q[k].b == op)) begin
                if (!rt && act && ((h - start) <= d + pl)) begin
                    dr = 1'b1;
                end else begin
                    start = h;
                    act   = 1;
                end
            end
        end
        t = act && ((c - start) >= d) && ((c - start) <= d + pl - 1);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic compare_all();
        logic       e_vld;
        logic [7:0] e_dat;
        logic [3:0] e_trg;
        logic [3:0] e_drp;
        logic       t1;
        logic       d1;
        e_vld = 1'b0;
        e_dat = 8'h00;
        foreach (cap_q[k]) begin
            if (cap_q[k].t > last_rst) begin
                if (cap_q[k].t + 1 == cyc) e_vld = 1'b1;
                if (cap_q[k].t + 1 <= cyc) e_dat = cap_q[k].b;
            end
        end
        for (int g = 0; g < ND; g++) begin
            for (int ch = 0; ch < 4; ch++) begin
                model_ch(p_dly(g), p_pl(g), RT_PK[g], OPCODES[8*ch +: 8], cyc, t1, d1);
                e_trg[ch] = t1;
                e_drp[ch] = d1;
            end
            checkOutput($sformatf("op_vld%0d", g), 32'(vld[g]), 32'(e_vld));
            checkOutput($sformatf("op_data%0d", g), 32'(dat[g]), 32'(e_dat));
            checkOutput($sformatf("trg_pls%0d", g), 32'(trg[g]), 32'(e_trg));
            checkOutput($sformatf("drop%0d", g), 32'(drp[g]), 32'(e_drp));
        end
    endtask

    task automatic clear_meas();
        vld_cnt = 0;
        for (int g = 0; g < ND; g++) begin
            for (int ch = 0; ch < 4; ch++) begin
                hi_cnt[g][ch]   = 0;
                first_hi[g][ch] = -1;
                rise_cnt[g][ch] = 0;
            end
            prev_trg[g] = trg[g];
        end
    endtask

    // One clock step: compare against the model, then update measurements.
    task automatic tick();
        @(negedge clk);
        if (chk_en) begin
            compare_all();
        end
        if (vld[0] === 1'b1) vld_cnt++;
        for (int g = 0; g < ND; g++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (trg[g][ch] === 1'b1) begin
                    hi_cnt[g][ch]++;
                    if (first_hi[g][ch] < 0) first_hi[g][ch] = cyc;
                    if (prev_trg[g][ch] !== 1'b1) rise_cnt[g][ch]++;
                end
            end
            prev_trg[g] = trg[g];
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // One SPI mode-0 transaction of nbits bits (MSB first from bits[nbits-1:0]).
    // Returns the DUT edge at which the instruction byte completes, or -1.
    task automatic applyStimulus(input logic [31:0] bits, input int nbits,
                                 input int half, output int t_cap);
        logic [7:0] acc;
        acc   = 8'h00;
        t_cap = -1;
        cs = 1'b0;
        idle(2);
        for (int i = 0; i < nbits; i++) begin
            mosi = bits[nbits-1-i];
            idle(half);
            sclk = 1'b1;
            if (i < 8) acc = {acc[6:0], bits[nbits-1-i]};
            if (i == 7) begin
                t_cap = cyc + 1 + S;
                cap_q.push_back('{t: t_cap, b: acc});
            end
            idle(half);
            sclk = 1'b0;
        end
        idle(2);
        cs = 1'b1;
        idle(6);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        idle(n);
        rst = 1'b0;
    endtask

    initial begin
        int t1;
        int t2;
        logic [7:0] b;
        $display("[TB] start");
        do_reset(3);
        idle(2);
        chk_en = 1;
        clear_meas();
        checkOutput("reset_op_data", 32'(dat[0]), 32'h00);
        checkOutput("reset_trg", 32'(trg[0]), 32'h0);

        // Opcode 0x02 on channel 0 with no delay and a 15-cycle pulse.
        clear_meas();
        applyStimulus(32'h02, 8, 2, t1);
        idle(30);
        checkOutput("a_vld_count", 32'(vld_cnt), 32'd1);
        checkOutput("a_op_data", 32'(dat[0]), 32'h02);
        checkOutput("a_pulse_len", 32'(hi_cnt[0][0]), 32'd15);
        checkOutput("a_pulse_start", 32'(first_hi[0][0]), 32'(t1 + 2));
        checkOutput("a_other_ch", 32'(hi_cnt[0][1] + hi_cnt[0][2] + hi_cnt[0][3]), 32'd0);

        // Opcode 0x84 on instance 1: five cycles of delay, three-cycle pulse.
        clear_meas();
        applyStimulus(32'h84, 8, 3, t1);
        idle(20);
        checkOutput("b_pulse_len", 32'(hi_cnt[1][2]), 32'd3);
        checkOutput("b_pulse_start", 32'(first_hi[1][2]), 32'(t1 + 7));

        // Partial byte (first five bits of 0x02) then a full 0x55.
        clear_meas();
        applyStimulus(32'h00, 5, 2, t1);
        applyStimulus(32'h55, 8, 2, t1);
        idle(10);
        checkOutput("c_vld_count", 32'(vld_cnt), 32'd1);
        checkOutput("c_op_data", 32'(dat[0]), 32'h55);
        checkOutput("c_no_pulse", 32'(hi_cnt[0][0] + hi_cnt[0][1] + hi_cnt[0][2] + hi_cnt[0][3]), 32'd0);
        checkOutput("c_drop", 32'(drp[0]), 32'h0);

        // Two back-to-back 0x10: the second lands inside the 60-cycle pulse.
        clear_meas();
        applyStimulus(32'h10, 8, 2, t1);
        applyStimulus(32'h10, 8, 2, t2);
        idle(80);
        checkOutput("d_noretrig_len", 32'(hi_cnt[2][1]), 32'd60);
        checkOutput("d_noretrig_drop", 32'(drp[2][1]), 32'd1);
        checkOutput("d_retrig_len", 32'(hi_cnt[3][1]), 32'(t2 - t1 + 60));
        checkOutput("d_retrig_rises", 32'(rise_cnt[3][1]), 32'd1);
        checkOutput("d_retrig_drop", 32'(drp[3]), 32'h0);

        // 0x13 followed by three more bytes under the same CS.
        clear_meas();
        applyStimulus(32'h13AA_5502, 32, 2, t1);
        idle(25);
        checkOutput("e_vld_count", 32'(vld_cnt), 32'd1);
        checkOutput("e_op_data", 32'(dat[0]), 32'h13);
        checkOutput("e_rises", 32'(rise_cnt[0][3]), 32'd1);
        checkOutput("e_ch0_quiet", 32'(hi_cnt[0][0]), 32'd0);

        // Reset in the middle of a channel-0 pulse.
        applyStimulus(32'h02, 8, 2, t1);
        checkOutput("f_mid_pulse", 32'(trg[0][0]), 32'd1);
        rst = 1'b1;
        tick();
        checkOutput("f_trg_cleared", 32'(trg[0]), 32'h0);
        checkOutput("f_drop_cleared", 32'(drp[2]), 32'h0);
        checkOutput("f_data_cleared", 32'(dat[0]), 32'h00);
        idle(2);
        rst = 1'b0;
        idle(3);
        clear_meas();
        applyStimulus(32'h02, 8, 2, t1);
        idle(25);
        checkOutput("f_after_reset_len", 32'(hi_cnt[0][0]), 32'd15);

        // Random traffic: opcodes mixed with arbitrary bytes and spacing.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                b = OPCODES[8*$urandom_range(0, 3) +: 8];
            end else begin
                b = 8'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 7) == 0) begin
                applyStimulus(32'(b >> 3), 5, 2, t1);
            end else if ($urandom_range(0, 7) == 0) begin
                applyStimulus({b, 8'($urandom_range(0, 255))}, 16, 2, t1);
            end else begin
                applyStimulus(32'(b), 8, $urandom_range(2, 3), t1);
            end
            idle($urandom_range(0, 60));
        end
        idle(80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
